quadrature_gen: RTL and testbench

- Synthesizable, parametrised quadrature encoder emulator. Replaces ad-hoc bench stimulus with a command-driven source of A/B/Z waveforms.
- Drives `quadrature` decoder inputs, in benches or in hardware loopback self-test.
- Each command gives a step count, a step period and a direction. Optional fault injection produces an illegal transition, to exercise decoder `hw_err`.

---
 rtl/quadrature_gen.sv | 157 +++++++++++++++
 tb/tb_quadrature_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_gen.sv
// Command-driven quadrature encoder emulator producing A/B/Z waveforms.
// Each accepted command walks the stage ring a given number of steps at a fixed cadence.
module quadrature_gen #(
    parameter int COUNTER_WIDTH = 32,
    parameter int INDEX_PERIOD  = 0,
    parameter int RESET_STAGE   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [COUNTER_WIDTH-1:0] cmd_steps,
    input  logic [COUNTER_WIDTH-1:0] cmd_period,
    input  logic                     cmd_dir,
    input  logic                     cmd_fault,
    input  logic                     abort,
    input  logic                     position_clear,
    output logic                     out_a,
    output logic                     out_b,
    output logic                     out_z,
    output logic                     busy,
    output logic                     done,
    output logic [COUNTER_WIDTH-1:0] position
);
    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // RUN   | counting period cycles and advancing the stage
    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [1:0] stage_code(input logic [1:0] s);
        case (s)
            2'd0:    return 2'b11;
            2'd1:    return 2'b10;
            2'd2:    return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    localparam logic [1:0]               RST_STAGE = 2'(RESET_STAGE);
    localparam logic [1:0]               RST_CODE  = stage_code(RST_STAGE);
    localparam logic [COUNTER_WIDTH-1:0] ONE       = COUNTER_WIDTH'(1);
    localparam bit                       IDX_EN    = (INDEX_PERIOD != 0);
    localparam logic [COUNTER_WIDTH-1:0] IDX_LAST  =
        (INDEX_PERIOD > 0) ? COUNTER_WIDTH'(INDEX_PERIOD - 1) : '0;

    state_t                   state, state_nxt;
    logic [1:0]               stage, stage_nxt;
    logic [COUNTER_WIDTH-1:0] timer, timer_nxt;
    logic [COUNTER_WIDTH-1:0] remaining, remaining_nxt;
    logic [COUNTER_WIDTH-1:0] period_q, period_nxt;
    logic [COUNTER_WIDTH-1:0] idx, idx_nxt;
    logic [COUNTER_WIDTH-1:0] position_nxt;
    logic                     dir_q, dir_nxt;
    logic                     fault_q, fault_nxt;
    logic                     done_nxt;
    logic [1:0]               ab_nxt;
    logic                     z_nxt;

    assign busy      = (state == RUN);
    assign cmd_ready = ~busy;

    always_comb begin
        state_nxt     = state;
        stage_nxt     = stage;
        timer_nxt     = timer;
        remaining_nxt = remaining;
        period_nxt    = period_q;
        idx_nxt       = idx;
        position_nxt  = position;
        dir_nxt       = dir_q;
        fault_nxt     = fault_q;
        done_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    dir_nxt       = cmd_dir;
                    fault_nxt     = cmd_fault;
                    period_nxt    = cmd_period;
                    timer_nxt     = cmd_period;
                    remaining_nxt = cmd_steps;
                    if (cmd_steps == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (timer != '0) begin
                    timer_nxt = timer - ONE;
                end else begin
                    timer_nxt     = period_q;
                    remaining_nxt = remaining - ONE;
                    // A faulted advance skips a stage and is not counted as motion
                    if (fault_q) begin
                        stage_nxt = stage + 2'd2;
                        fault_nxt = 1'b0;
                    end else if (dir_q) begin
                        stage_nxt    = stage + 2'd1;
                        position_nxt = position + ONE;
                        if (IDX_EN) idx_nxt = (idx == IDX_LAST) ? '0 : idx + ONE;
                    end else begin
                        stage_nxt    = stage - 2'd1;
                        position_nxt = position - ONE;
                        if (IDX_EN) idx_nxt = (idx == '0) ? IDX_LAST : idx - ONE;
                    end
                    if (remaining == ONE) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (position_clear) position_nxt = '0;

        ab_nxt = stage_code(stage_nxt);
        z_nxt  = IDX_EN && (idx_nxt == '0) && (stage_nxt == 2'd0);
    end

    // Outputs are flopped from the next-stage decode so A/B/Z never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stage     <= RST_STAGE;
            timer     <= '0;
            remaining <= '0;
            period_q  <= '0;
            idx       <= '0;
            position  <= '0;
            dir_q     <= 1'b0;
            fault_q   <= 1'b0;
            done      <= 1'b0;
            out_a     <= RST_CODE[1];
            out_b     <= RST_CODE[0];
            out_z     <= 1'b0;
        end else begin
            state     <= state_nxt;
            stage     <= stage_nxt;
            timer     <= timer_nxt;
            remaining <= remaining_nxt;
            period_q  <= period_nxt;
            idx       <= idx_nxt;
            position  <= position_nxt;
            dir_q     <= dir_nxt;
            fault_q   <= fault_nxt;
            done      <= done_nxt;
            out_a     <= ab_nxt[1];
            out_b     <= ab_nxt[0];
            out_z     <= z_nxt;
        end
    end
endmodule

// File: tb/tb_quadrature_gen.sv
// Self-checking bench for quadrature_gen: command table, corner sequences and random traffic
// compared every cycle against an arithmetic schedule model.
module tb_quadrature_gen;
    localparam int CW = 32;
    localparam int IP = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_steps;
    logic [CW-1:0] cmd_period;
    logic          cmd_dir;
    logic          cmd_fault;
    logic          abort;
    logic          position_clear;
    logic          out_a, out_b, out_z;
    logic          busy, done;
    logic [CW-1:0] position;

    always #5 clk = ~clk;

    quadrature_gen #(.COUNTER_WIDTH(CW), .INDEX_PERIOD(IP), .RESET_STAGE(0)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_period(cmd_period), .cmd_dir(cmd_dir),
        .cmd_fault(cmd_fault), .abort(abort), .position_clear(position_clear),
        .out_a(out_a), .out_b(out_b), .out_z(out_z), .busy(busy), .done(done),
        .position(position)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: advance k of a command lands k*(period+1) edges after acceptance
    bit            m_busy, m_done, m_z, m_dir, m_fault;
    int            m_stage, m_idx, m_steps, m_period;
    logic [CW-1:0] m_pos;
    longint        cyc = 0;
    longint        n0;

    typedef struct {
        int         steps;
        int         period;
        bit         dir;
        bit         fault;
        logic [1:0] exp_ab;
        logic [CW-1:0] exp_pos;
        int         exp_lat;
    } vec_t;

    function automatic logic [1:0] enc(input int s);
        case (s)
            0:       return 2'b11;
            1:       return 2'b10;
            2:       return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_z = 0; m_dir = 0; m_fault = 0;
        m_stage = 0; m_idx = 0; m_steps = 0; m_period = 0; m_pos = '0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string name);
        logic [63:0] act, exp;
        act = {26'd0, out_a, out_b, out_z, busy, done, cmd_ready, position};
        exp = {26'd0, enc(m_stage), m_z, m_busy, m_done, !m_busy, m_pos};
        check(name, act, exp);
    endtask

    task automatic step();
        bit     v, ab, pc, d, f;
        int     s, p;
        longint dd, k;
        v = cmd_valid; ab = abort; pc = position_clear; d = cmd_dir; f = cmd_fault;
        s = int'(cmd_steps); p = int'(cmd_period);
        @(posedge clk);
        cyc++;
        m_done = 0;
        if (!m_busy) begin
            if (v) begin
                if (s == 0) m_done = 1;
                else begin
                    m_busy = 1; n0 = cyc; m_steps = s; m_period = p; m_dir = d; m_fault = f;
                end
            end
        end else if (ab) begin
            m_busy = 0;
        end else begin
            dd = cyc - n0;
            if (dd % (m_period + 1) == 0) begin
                k = dd / (m_period + 1);
                if (k == 1 && m_fault) m_stage = (m_stage + 2) % 4;
                else if (m_dir) begin
                    m_stage = (m_stage + 1) % 4; m_pos = m_pos + 1; m_idx = (m_idx + 1) % IP;
                end else begin
                    m_stage = (m_stage + 3) % 4; m_pos = m_pos - 1; m_idx = (m_idx + IP - 1) % IP;
                end
                if (k == m_steps) begin
                    m_busy = 0; m_done = 1;
                end
            end
        end
        if (pc) m_pos = '0;
        m_z = (m_idx == 0) && (m_stage == 0);
        #1;
        check_outputs("cycle");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs("reset");
        rst_n = 1'b1;
    endtask

    task automatic issue(input int s, input int p, input bit d, input bit f);
        cmd_steps = CW'(s); cmd_period = CW'(p); cmd_dir = d; cmd_fault = f;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        issue(v.steps, v.period, v.dir, v.fault);
        lat = 0;
        while (!done && lat < 2000) begin
            step();
            lat++;
        end
        check("latency", 64'(lat), 64'(v.exp_lat));
        check("final_ab", {62'd0, out_a, out_b}, {62'd0, v.exp_ab});
        check("final_position", 64'(position), 64'(v.exp_pos));
        step();
    endtask

    task automatic run_index(input int s, input int p, input bit d, input int exp_z);
        int zc;
        issue(s, p, d, 1'b0);
        zc = 0;
        for (int i = 0; i < s * (p + 1); i++) begin
            step();
            if (out_z) zc++;
        end
        check("z_count", 64'(zc), 64'(exp_z));
        check("index_busy_low", {63'd0, busy}, 64'd0);
        step();
    endtask

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        logic [1:0] ab_before;

        vecs[0] = '{8, 0, 1'b1, 1'b0, 2'b11, 32'd8, 8};
        vecs[1] = '{3, 4, 1'b0, 1'b0, 2'b10, 32'd5, 15};
        vecs[2] = '{1, 2, 1'b0, 1'b0, 2'b11, 32'd4, 3};
        vecs[3] = '{2, 0, 1'b1, 1'b1, 2'b01, 32'd5, 2};
        vecs[4] = '{0, 7, 1'b1, 1'b0, 2'b01, 32'd5, 0};
        vecs[5] = '{5, 1, 1'b0, 1'b1, 2'b10, 32'd1, 10};
        vecs[6] = '{4, 0, 1'b0, 1'b0, 2'b10, 32'hFFFF_FFFD, 4};

        rst_n = 1'b0; cmd_valid = 0; cmd_steps = '0; cmd_period = '0;
        cmd_dir = 0; cmd_fault = 0; abort = 0; position_clear = 0;
        #12;
        model_reset();
        check_outputs("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Index pulse: idle at stage 0 / index 0, then 16 forward and 8 reverse
        step();
        do_reset();
        step();
        check("z_idle", {63'd0, out_z}, 64'd1);
        run_index(16, 1, 1'b1, 4);
        run_index(8, 0, 1'b0, 1);

        // Abort on the second cycle of a slow command
        issue(5, 10, 1'b1, 1'b0);
        ab_before = enc(m_stage);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_state", {61'd0, busy, done, out_a, out_b} & 64'hF,
              {62'd0, ab_before});
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'd0);

        // position_clear coincident with the second advance
        position_clear = 1'b1;
        step();
        position_clear = 1'b0;
        issue(3, 0, 1'b1, 1'b0);
        step();
        position_clear = 1'b1;
        step();
        position_clear = 1'b0;
        check("clear_wins", 64'(position), 64'd0);
        step();
        check("after_clear", 64'(position), 64'd1);
        step();

        // Commands offered while busy are ignored
        issue(4, 2, 1'b1, 1'b0);
        cmd_valid = 1'b1; cmd_steps = CW'(1); cmd_dir = 1'b0;
        for (int i = 0; i < 6; i++) step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // Asynchronous reset mid-command
        issue(6, 3, 1'b0, 1'b0);
        step();
        step();
        #2;
        do_reset();
        step();

        for (int i = 0; i < 1500; i++) begin
            cmd_valid      = ($urandom_range(0, 2) == 0);
            cmd_steps      = CW'($urandom_range(0, 10));
            cmd_period     = CW'($urandom_range(0, 3));
            cmd_dir        = 1'($urandom_range(0, 1));
            cmd_fault      = ($urandom_range(0, 3) == 0);
            abort          = ($urandom_range(0, 29) == 0);
            position_clear = ($urandom_range(0, 24) == 0);
            if (i == 700) begin
                #2;
                do_reset();
            end
            step();
        end
        cmd_valid = 0; abort = 0; position_clear = 0;
        for (int i = 0; i < 5; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
